encoder_round_sequencer: RTL

//  Top-level sequencer for the 5x5x64 encoder permutation datapath. On start it loads 64 state lines

---
 rtl/encoder_pkg.sv | 28 ++
 rtl/seq_counter.sv | 36 +++
 rtl/encoder_round_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared constants for the encoder round sequencer: FSM encoding, step indices and default sizes.
package encoder_pkg;

    localparam int unsigned LINES_DEF    = 64;
    localparam int unsigned ROUNDS_DEF   = 24;
    localparam int unsigned STEP_TMO_DEF = 255;
    localparam int unsigned N_STEPS      = 5;
    localparam int unsigned STATE_W      = 3;
    localparam int unsigned STEP_W       = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_LOAD  = 3'd1;
    localparam logic [STATE_W-1:0] S_STEP  = 3'd2;
    localparam logic [STATE_W-1:0] S_STORE = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd4;
    localparam logic [STATE_W-1:0] S_ERR   = 3'd5;

    localparam logic [STEP_W-1:0] STEP_COLPAR  = 3'd0;
    localparam logic [STEP_W-1:0] STEP_ROTATE  = 3'd1;
    localparam logic [STEP_W-1:0] STEP_PERMUTE = 3'd2;
    localparam logic [STEP_W-1:0] STEP_REVAL   = 3'd3;
    localparam logic [STEP_W-1:0] STEP_ADDRC   = 3'd4;

    function automatic logic [N_STEPS-1:0] step_onehot(input logic [STEP_W-1:0] k);
        step_onehot = N_STEPS'(1) << k;
    endfunction

endpackage

// File: rtl/seq_counter.sv
// Saturating up-counter with synchronous clear; 'last' flags the terminal count so passes never wrap.
module seq_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             last
);

    logic [WIDTH-1:0] value_q, value_d;

    assign last  = (value_q == WIDTH'(MAX));
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (en && !last) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/encoder_round_sequencer.sv
// Sequences load, ROUNDS x five permutation steps and write-back for the 5x5x64 encoder datapath.
module encoder_round_sequencer
    import encoder_pkg::*;
#(
    parameter int unsigned LINES    = LINES_DEF,
    parameter int unsigned ADDR_W   = $clog2(LINES),
    parameter int unsigned ROUNDS   = ROUNDS_DEF,
    parameter int unsigned RND_W    = $clog2(ROUNDS),
    parameter int unsigned STEP_TMO = STEP_TMO_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               load_en,
    output logic [ADDR_W-1:0]  load_addr,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [RND_W-1:0]   round_idx,
    output logic [N_STEPS-1:0] step_en,
    input  logic [N_STEPS-1:0] step_done
);

    localparam int unsigned TMO_W = $clog2(STEP_TMO);

    logic [STATE_W-1:0] state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               rd_en_q, rd_en_d, load_en_q, load_en_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  load_addr_q, load_addr_d;
    logic [N_STEPS-1:0] step_en_q, step_en_d;

    logic               line_en, line_clr, line_last;
    logic [ADDR_W-1:0]  line_value;
    logic               rnd_en, rnd_clr, rnd_last;
    logic [RND_W-1:0]   rnd_value;
    logic               tmo_en, tmo_clr, tmo_last;
    logic [TMO_W-1:0]   tmo_value_unused;
    logic               cur_done;

    assign cur_done = step_done[step_q];

    seq_counter #(.WIDTH(ADDR_W), .MAX(LINES - 1)) u_line_cnt (
        .clk(clk), .rst(rst), .en(line_en), .clr(line_clr), .value(line_value), .last(line_last)
    );

    seq_counter #(.WIDTH(RND_W), .MAX(ROUNDS - 1)) u_round_cnt (
        .clk(clk), .rst(rst), .en(rnd_en), .clr(rnd_clr), .value(rnd_value), .last(rnd_last)
    );

    seq_counter #(.WIDTH(TMO_W), .MAX(STEP_TMO - 1)) u_tmo_cnt (
        .clk(clk), .rst(rst), .en(tmo_en), .clr(tmo_clr), .value(tmo_value_unused), .last(tmo_last)
    );

    // Next state, counter control and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        line_en  = 1'b0;
        line_clr = 1'b1;
        rnd_en   = 1'b0;
        rnd_clr  = (state_q != S_STEP);
        tmo_en   = 1'b0;
        tmo_clr  = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_LOAD;
            end
            S_LOAD: begin
                // rd_en already low means this is the one-cycle read-latency drain
                line_en  = rd_en_q;
                line_clr = !rd_en_q;
                if (!rd_en_q) begin
                    state_d = S_STEP;
                    step_d  = STEP_COLPAR;
                end
            end
            S_STEP: begin
                if (cur_done) begin
                    if (step_q == STEP_ADDRC) begin
                        step_d = STEP_COLPAR;
                        if (rnd_last) state_d = S_STORE;
                        else          rnd_en  = 1'b1;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end else begin
                    tmo_en  = 1'b1;
                    tmo_clr = 1'b0;
                    if (tmo_last) state_d = S_ERR;
                end
            end
            S_STORE: begin
                line_en  = 1'b1;
                line_clr = 1'b0;
                if (line_last) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (start) state_d = S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d  = S_IDLE;
            line_en  = 1'b0;
            line_clr = 1'b1;
            rnd_en   = 1'b0;
            rnd_clr  = 1'b1;
            tmo_en   = 1'b0;
            tmo_clr  = 1'b1;
        end

        busy_d      = (state_d == S_LOAD) || (state_d == S_STEP) || (state_d == S_STORE);
        done_d      = (state_d == S_DONE);
        err_d       = (state_d == S_ERR);
        rd_en_d     = (state_d == S_LOAD) && !((state_q == S_LOAD) && line_last);
        load_en_d   = rd_en_q && (state_d == S_LOAD);
        load_addr_d = rd_en_q ? line_value : load_addr_q;
        wr_en_d     = (state_d == S_STORE);
        step_en_d   = (state_d == S_STEP) ? step_onehot(step_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= STEP_COLPAR;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            load_en_q   <= 1'b0;
            load_addr_q <= '0;
            wr_en_q     <= 1'b0;
            step_en_q   <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_en_q     <= rd_en_d;
            load_en_q   <= load_en_d;
            load_addr_q <= load_addr_d;
            wr_en_q     <= wr_en_d;
            step_en_q   <= step_en_d;
        end
    end

    // Read and write addresses share the line counter; only the matching strobe qualifies each
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = line_value;
    assign load_en   = load_en_q;
    assign load_addr = load_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = line_value;
    assign round_idx = rnd_value;
    assign step_en   = step_en_q;

endmodule
